// File: rtl/seed_loader_if.sv
// Configuration stream and parallel-output bundle between the seed loader
// (slave) and whoever feeds the stream and watches the commit (master).
interface seed_loader_if #(
    parameter int M = 8,
    parameter int W = 8
);
    logic             start;
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [0:M-1]     b_lfsr_set;
    logic [0:M*M-1]   b_trans_1_mat_set;
    logic [0:M*M-1]   b_trans_2_mat_set;
    logic             set;
    logic             gen_en;
    logic             busy;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, b_lfsr_set, b_trans_1_mat_set, b_trans_2_mat_set,
        input  set, gen_en, busy
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, b_lfsr_set, b_trans_1_mat_set, b_trans_2_mat_set,
        output set, gen_en, busy
    );
endinterface

// File: rtl/seed_loader.sv
// Assembles the data-LFSR seed and both transform matrices from a word-serial
// stream, presents them on stable buses and commits them with a one-cycle set.
module seed_loader #(
    parameter int M = 8,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    seed_loader_if.slave cfg
);
    localparam int TOTAL = M + 2 * M * M;
    localparam int NW    = (TOTAL + W - 1) / W;
    localparam int LAST  = TOTAL - (NW - 1) * W;
    localparam int CW    = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, LOAD, COPY, PULSE} state_t;

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [0:TOTAL-1]   shadow_r;
    logic [0:M-1]       seed_r;
    logic [0:M*M-1]     trans_1_r;
    logic [0:M*M-1]     trans_2_r;
    logic               loaded_r;
    logic               in_ready_r;
    logic               set_r;
    logic               gen_en_r;
    logic               busy_r;

    logic               accept_s;
    logic               last_s;
    logic [0:TOTAL-1]   shadow_next_s;

    // Word acceptance and next shadow value; the final word contributes only
    // its leading LAST bits so stream bit 0 lands at shadow index 0.
    always_comb begin
        accept_s      = cfg.in_valid && in_ready_r;
        last_s        = (cnt_r == CW'(NW - 1));
        shadow_next_s = shadow_r;
        if (last_s) begin
            shadow_next_s = {shadow_r[LAST:TOTAL-1], cfg.in_data[W-1 -: LAST]};
        end else begin
            shadow_next_s = {shadow_r[W:TOTAL-1], cfg.in_data};
        end
    end

    // Load sequencer with registered handshake, commit and enable outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            shadow_r   <= '0;
            seed_r     <= '0;
            trans_1_r  <= '0;
            trans_2_r  <= '0;
            loaded_r   <= 1'b0;
            in_ready_r <= 1'b0;
            set_r      <= 1'b0;
            gen_en_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cfg.start) begin
                        state_r    <= LOAD;
                        cnt_r      <= '0;
                        loaded_r   <= 1'b0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        gen_en_r   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        shadow_r <= shadow_next_s;
                        cnt_r    <= cnt_r + CW'(1);
                        if (last_s) begin
                            state_r    <= COPY;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                COPY: begin
                    seed_r    <= shadow_r[0:M-1];
                    trans_1_r <= shadow_r[M:M+M*M-1];
                    trans_2_r <= shadow_r[M+M*M:TOTAL-1];
                    set_r     <= 1'b1;
                    state_r   <= PULSE;
                end
                PULSE: begin
                    set_r    <= 1'b0;
                    loaded_r <= 1'b1;
                    gen_en_r <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                    set_r      <= 1'b0;
                    gen_en_r   <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign cfg.in_ready          = in_ready_r;
    assign cfg.b_lfsr_set        = seed_r;
    assign cfg.b_trans_1_mat_set = trans_1_r;
    assign cfg.b_trans_2_mat_set = trans_2_r;
    assign cfg.set               = set_r;
    assign cfg.gen_en            = gen_en_r;
    assign cfg.busy              = busy_r;
endmodule

// File: tb/tb_seed_loader.sv
// Self-checking bench for seed_loader at M=4, W=8: table vectors, reset and
// start-abuse sequences, then random streams against a bit-queue model.
module tb_seed_loader;
    localparam int M  = 4;
    localparam int W  = 8;
    localparam int MM = M * M;

    logic clk = 1'b0;
    logic rst;

    seed_loader_if #(.M(M), .W(W)) bus ();
    seed_loader #(.M(M), .W(W)) dut (.clk(clk), .rst(rst), .cfg(bus.slave));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [M-1:0]  held_seed;
    logic [MM-1:0] held_t1;
    logic [MM-1:0] held_t2;

    typedef struct packed {
        logic [39:0]   words;
        logic [M-1:0]  seed;
        logic [MM-1:0] t1;
        logic [MM-1:0] t2;
        logic [1:0]    mode;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: flatten the words MSB-first into a bit queue, then slice fields.
    task automatic model(input logic [39:0] words, output logic [M-1:0] s,
                         output logic [MM-1:0] t1, output logic [MM-1:0] t2);
        bit q[$];
        for (int i = 0; i < 5; i++)
            for (int b = 7; b >= 0; b--)
                q.push_back(words[(4 - i) * 8 + b]);
        s = '0; t1 = '0; t2 = '0;
        for (int i = 0; i < M; i++)  s  = {s[M-2:0], q[i]};
        for (int i = 0; i < MM; i++) t1 = {t1[MM-2:0], q[M + i]};
        for (int i = 0; i < MM; i++) t2 = {t2[MM-2:0], q[M + MM + i]};
    endtask

    // mode: 0 valid always, 1 valid 1,0,0 pattern, 2 random valid, 3 pattern plus stray start pulses
    task automatic do_load(input string tag, input logic [39:0] words, input int mode,
                           input logic [M-1:0] es, input logic [MM-1:0] et1, input logic [MM-1:0] et2);
        int   idx = 0;
        int   k = 0;
        logic v;
        bit   ready_ok = 1'b1;
        bit   held_ok = 1'b1;
        bit   quiet_ok = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check($sformatf("%s_busy_load", tag), bus.busy, 1);
        while (idx < 5 && k < 100) begin
            case (mode)
                0:       v = 1'b1;
                1, 3:    v = (k % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = v ? words[(4 - idx) * 8 +: 8] : 8'($urandom);
            if (mode == 3) bus.start = 1'($urandom_range(0, 1));
            if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
            if (bus.gen_en !== 1'b0 || bus.set !== 1'b0) quiet_ok = 1'b0;
            if (bus.b_lfsr_set !== held_seed || bus.b_trans_1_mat_set !== held_t1 ||
                bus.b_trans_2_mat_set !== held_t2) held_ok = 1'b0;
            tick();
            if (v) idx++;
            k++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check($sformatf("%s_words_accepted", tag), idx, 5);
        check($sformatf("%s_ready_in_load", tag), ready_ok, 1);
        check($sformatf("%s_quiet_in_load", tag), quiet_ok, 1);
        check($sformatf("%s_old_bus_held", tag), held_ok, 1);
        // Copy cycle: buses not yet updated, no pulse, not ready
        check($sformatf("%s_copy_set", tag), bus.set, 0);
        check($sformatf("%s_copy_ready", tag), bus.in_ready, 0);
        check($sformatf("%s_copy_seed_old", tag), bus.b_lfsr_set, held_seed);
        tick();
        check($sformatf("%s_pulse_set", tag), bus.set, 1);
        check($sformatf("%s_pulse_gen_en", tag), bus.gen_en, 0);
        check($sformatf("%s_seed", tag), bus.b_lfsr_set, es);
        check($sformatf("%s_trans1", tag), bus.b_trans_1_mat_set, et1);
        check($sformatf("%s_trans2", tag), bus.b_trans_2_mat_set, et2);
        if (mode == 3) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check($sformatf("%s_idle_set", tag), bus.set, 0);
        check($sformatf("%s_idle_gen_en", tag), bus.gen_en, 1);
        check($sformatf("%s_idle_busy", tag), bus.busy, 0);
        check($sformatf("%s_idle_trans2", tag), bus.b_trans_2_mat_set, et2);
        if (mode == 3) begin
            tick();
            check($sformatf("%s_start_in_pulse_ignored", tag), bus.busy, 0);
            check($sformatf("%s_no_second_set", tag), bus.set, 0);
        end
        held_seed = es;
        held_t1   = et1;
        held_t2   = et2;
    endtask

    initial begin
        vec_t          vt [6];
        logic [39:0]   w;
        logic [M-1:0]  es;
        logic [MM-1:0] et1;
        logic [MM-1:0] et2;

        vt[0] = '{40'hA53C0FF090, 4'hA, 16'h53C0, 16'hFF09, 2'd0};
        vt[1] = '{40'hA53C0FF09F, 4'hA, 16'h53C0, 16'hFF09, 2'd1};
        vt[2] = '{40'hFFFFFFFFFF, 4'hF, 16'hFFFF, 16'hFFFF, 2'd3};
        vt[3] = '{40'h123456789A, 4'h1, 16'h2345, 16'h6789, 2'd2};
        vt[4] = '{40'h0000000000, 4'h0, 16'h0000, 16'h0000, 2'd0};
        vt[5] = '{40'hA53C0FF090, 4'hA, 16'h53C0, 16'hFF09, 2'd3};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        held_seed = '0;
        held_t1 = '0;
        held_t2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_set", bus.set, 0);
        check("rst_gen_en", bus.gen_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_seed", bus.b_lfsr_set, 0);
        check("rst_trans1", bus.b_trans_1_mat_set, 0);
        check("rst_trans2", bus.b_trans_2_mat_set, 0);

        for (int i = 0; i < 6; i++)
            do_load($sformatf("vec%0d", i), vt[i].words, int'(vt[i].mode),
                    vt[i].seed, vt[i].t1, vt[i].t2);

        // Abort a load after three words with an asynchronous reset
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 8'hC3 ^ 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_seed", bus.b_lfsr_set, 0);
        check("async_rst_trans1", bus.b_trans_1_mat_set, 0);
        check("async_rst_trans2", bus.b_trans_2_mat_set, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_in_ready", bus.in_ready, 0);
        check("async_rst_gen_en", bus.gen_en, 0);
        tick();
        rst = 1'b0;
        tick();
        held_seed = '0;
        held_t1 = '0;
        held_t2 = '0;
        w = 40'h5AC3F0E1B7;
        model(w, es, et1, et2);
        do_load("after_rst", w, 0, es, et1, et2);

        for (int r = 0; r < 10; r++) begin
            w = {32'($urandom), 8'($urandom)};
            model(w, es, et1, et2);
            do_load($sformatf("rand%0d", r), w, int'($urandom_range(0, 3)), es, et1, et2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
